// File: rtl/shift_pkg.sv
// Shared constants for the iterative shifter: mode and direction encodings
// plus the controller state type.
package shift_pkg;

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;

    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-position shifter stage: moves value one bit left or right and
// reports the bit that falls off the end. Mode 2'b11 behaves as logical.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] shifted,
    output logic             out_bit
);

    // One-bit move; the fill bit depends on direction and mode.
    always_comb begin
        shifted = value;
        out_bit = 1'b0;
        case (dir)
            DIR_R: begin
                out_bit = value[0];
                case (mode)
                    MODE_ARI: shifted = {value[WIDTH-1], value[WIDTH-1:1]};
                    MODE_ROT: shifted = {value[0], value[WIDTH-1:1]};
                    MODE_LOG: shifted = {1'b0, value[WIDTH-1:1]};
                    default:  shifted = {1'b0, value[WIDTH-1:1]};
                endcase
            end
            DIR_L: begin
                out_bit = value[WIDTH-1];
                if (mode == MODE_ROT) begin
                    shifted = {value[WIDTH-2:0], value[WIDTH-1]};
                end else begin
                    shifted = {value[WIDTH-2:0], 1'b0};
                end
            end
            default: begin
                shifted = value;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Iterative WIDTH-bit shifter: one position per clock, logical/arithmetic/
// rotate, start/busy/done handshake.
// Optional build macro SHIFT_CARRY_EN adds carry_out (last bit shifted out).
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | applying one step per edge, count holds steps remaining
// DONE  | one-cycle done pulse; start here reloads back-to-back
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter  int WIDTH   = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] amt,
    input  logic               dir,
    input  logic [1:0]         mode,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
`ifdef SHIFT_CARRY_EN
    ,
    output logic               carry_out
`endif
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    state_t             state;
    logic [SHAMT_W-1:0] count;
    logic               dir_q;
    logic [1:0]         mode_q;
    logic [WIDTH-1:0]   step_val;
`ifdef SHIFT_CARRY_EN
    logic               step_bit;
`else
    logic               unused_step_bit;
`endif

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .value   (result),
        .dir     (dir_q),
        .mode    (mode_q),
        .shifted (step_val),
`ifdef SHIFT_CARRY_EN
        .out_bit (step_bit)
`else
        .out_bit (unused_step_bit)
`endif
    );

    // Controller: accepts work in IDLE/DONE, walks the shift count down in SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            count     <= '0;
            dir_q     <= DIR_R;
            mode_q    <= MODE_LOG;
`ifdef SHIFT_CARRY_EN
            carry_out <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        result    <= din;
                        count     <= amt;
                        dir_q     <= dir;
                        mode_q    <= mode;
`ifdef SHIFT_CARRY_EN
                        carry_out <= 1'b0;
`endif
                        if (amt != '0) begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                SHIFT: begin
                    result    <= step_val;
                    count     <= count - CNT_ONE;
`ifdef SHIFT_CARRY_EN
                    carry_out <= step_bit;
`endif
                    if (count == CNT_ONE) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq (WIDTH=8) with a behavioural
// reference model; carry_out is checked when SHIFT_CARRY_EN is defined.
module tb_shift_unit_seq;

    localparam int W  = 8;
    localparam int SW = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  din;
    logic [SW-1:0] amt;
    logic          dir;
    logic [1:0]    mode;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
`ifdef SHIFT_CARRY_EN
    logic          carry_out;
`endif

    int total;
    int bad;
    logic [W-1:0] last_exp;
    logic         last_cy;

    shift_unit_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .din       (din),
        .amt       (amt),
        .dir       (dir),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .result    (result)
`ifdef SHIFT_CARRY_EN
        ,
        .carry_out (carry_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole shift in one arithmetic expression.
    function automatic logic [W-1:0] ref_res(input logic [W-1:0] d, input int n,
                                             input logic dr, input logic [1:0] md);
        logic signed [W-1:0] s;
        s = d;
        if (n == 0) return d;
        if (dr == 1'b0) begin
            if (md == 2'b01) return W'(s >>> n);
            if (md == 2'b10) return W'((d >> n) | (d << (W - n)));
            return W'(d >> n);
        end
        if (md == 2'b10) return W'((d << n) | (d >> (W - n)));
        return W'(d << n);
    endfunction

    function automatic logic ref_cy(input logic [W-1:0] d, input int n, input logic dr);
        if (n == 0) return 1'b0;
        if (dr == 1'b0) return d[n-1];
        return d[W-n];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait (bounded) for done; check latency, busy time, result.
    task automatic run_op(input logic [W-1:0] d, input int n, input logic dr,
                          input logic [1:0] md, input string tag);
        int busy_cnt;
        int lat;
        start = 1'b1;
        din   = d;
        amt   = SW'(n);
        dir   = dr;
        mode  = md;
        tick();
        start = 1'b0;
        din   = W'($urandom);
        amt   = SW'($urandom);
        dir   = 1'($urandom);
        mode  = 2'($urandom);
        busy_cnt = 0;
        lat = -1;
        for (int i = 0; i < W + 4; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
            tick();
        end
        last_exp = ref_res(d, n, dr, md);
        last_cy  = ref_cy(d, n, dr);
        check({tag, "_lat"}, lat, n);
        check({tag, "_busy"}, busy_cnt, n);
        check({tag, "_res"}, result, last_exp);
`ifdef SHIFT_CARRY_EN
        check({tag, "_cy"}, carry_out, last_cy);
`endif
    endtask

    // Cycle after done with no new start: pulse gone, outputs held.
    task automatic check_idle_after(input string tag);
        tick();
        check({tag, "_pulse"}, done, 1'b0);
        check({tag, "_idlebusy"}, busy, 1'b0);
        check({tag, "_hold"}, result, last_exp);
`ifdef SHIFT_CARRY_EN
        check({tag, "_cyhold"}, carry_out, last_cy);
`endif
    endtask

    initial begin
        int  lat;
        logic saw_done;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b1;
        din   = 8'hFF;
        amt   = 3'd3;
        dir   = 1'b0;
        mode  = 2'b00;

        // Reset held two cycles with start asserted.
        tick();
        tick();
        check("rst_res", result, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
`ifdef SHIFT_CARRY_EN
        check("rst_cy", carry_out, 1'b0);
`endif
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);

        // Directed cases.
        run_op(8'hB4, 3, 1'b0, 2'b01, "rarith");
        check("rarith_val", result, 8'hF6);
        check_idle_after("rarith");
        run_op(8'h96, 2, 1'b1, 2'b10, "lrot");
        check("lrot_val", result, 8'h5A);
        check_idle_after("lrot");
        run_op(8'h96, 7, 1'b0, 2'b00, "rlog7");
        check("rlog7_val", result, 8'h01);
        check_idle_after("rlog7");
        run_op(8'h5C, 0, 1'b0, 2'b01, "zero");
        check("zero_val", result, 8'h5C);
        check_idle_after("zero");
        run_op(8'hC3, 3, 1'b0, 2'b11, "mode11");
        check_idle_after("mode11");

        // Back-to-back: second start issued in the DONE cycle.
        run_op(8'h81, 1, 1'b1, 2'b00, "b2b_a");
        run_op(8'h81, 4, 1'b0, 2'b10, "b2b_b");
        check_idle_after("b2b");

        // Start while busy is ignored.
        start = 1'b1; din = 8'hA5; amt = 3'd4; dir = 1'b0; mode = 2'b00;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; din = 8'hFF; amt = 3'd1; dir = 1'b1; mode = 2'b10;
        tick();
        start = 1'b0;
        lat = -1;
        for (int i = 0; i < W + 4; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            tick();
        end
        check("ign_lat", lat, 2);
        check("ign_res", result, 8'h0A);
        last_exp = 8'h0A;
        last_cy  = 1'b0;
        check_idle_after("ign");

        // Reset in the middle of a shift.
        start = 1'b1; din = 8'h81; amt = 3'd6; dir = 1'b1; mode = 2'b00;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy", busy, 1'b0);
        check("mid_done", done, 1'b0);
        check("mid_res", result, 8'h00);
        saw_done = 1'b0;
        for (int i = 0; i < W; i++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        check("mid_quiet", saw_done, 1'b0);
        run_op(8'h3C, 5, 1'b0, 2'b01, "after_rst");

        // Randomized ops against the reference model.
        for (int k = 0; k < 40; k++) begin
            run_op(W'($urandom), int'($urandom_range(0, W - 1)), 1'($urandom),
                   2'($urandom), "rnd");
            if ($urandom_range(0, 1) == 1) check_idle_after("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
